// File: rtl/latency_stats_if.sv
// Latency statistics bus: sample input, clear/sweep control, snapshot and
// histogram readout.
//   master : the producer/reader side (drives samples, clear, snap_req, rd addr)
//   slave  : the accumulator (drives busy, snapshot outputs, hist_rd_data)
interface latency_stats_if #(
    parameter int NUM_BINS = 16,
    parameter int CNT_W    = 32
);
    localparam int AW = $clog2(NUM_BINS);

    logic             in_valid;
    logic [63:0]      in_latency;
    logic [63:0]      in_update_id;
    logic             clear;
    logic             busy;
    logic             snap_req;
    logic             snap_valid;
    logic [CNT_W-1:0] snap_count;
    logic [63:0]      snap_min;
    logic [63:0]      snap_max;
    logic [63:0]      snap_sum;
    logic [CNT_W-1:0] snap_gaps;
    logic [CNT_W-1:0] snap_neg;
    logic [CNT_W-1:0] snap_drop;
    logic [AW-1:0]    hist_rd_addr;
    logic [CNT_W-1:0] hist_rd_data;

    modport master (
        output in_valid, in_latency, in_update_id, clear, snap_req, hist_rd_addr,
        input  busy, snap_valid, snap_count, snap_min, snap_max, snap_sum,
               snap_gaps, snap_neg, snap_drop, hist_rd_data
    );

    modport slave (
        input  in_valid, in_latency, in_update_id, clear, snap_req, hist_rd_addr,
        output busy, snap_valid, snap_count, snap_min, snap_max, snap_sum,
               snap_gaps, snap_neg, snap_drop, hist_rd_data
    );
endinterface

// File: rtl/latency_stats_accum.sv
// Latency statistics accumulator.
// Accumulates count/min/max/saturating sum of non-negative latencies, a
// clamped histogram, negative-sample and dropped-sample counts, and update_id
// sequence gaps. Scalar stats are exposed through atomic snapshots; bins are
// read through a registered 1-cycle port.
// Ports:
//   clk   : system clock
//   rst_n : async active-low reset (restarts the histogram sweep)
//   bus   : latency_stats_if slave modport (see interface for signal list)
//
// state   | meaning
// S_SWEEP | zeroing one histogram bin per cycle, busy=1, samples dropped
// S_RUN   | accepting samples
module latency_stats_accum #(
    parameter int NUM_BINS  = 16,
    parameter int BIN_SHIFT = 4,
    parameter int CNT_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    latency_stats_if.slave  bus
);
    localparam int AW = $clog2(NUM_BINS);

    typedef enum logic {S_SWEEP = 1'b0, S_RUN = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             busy, sweep_en;

    logic [CNT_W-1:0] count_q, count_d, gaps_q, gaps_d, neg_q, neg_d, drop_q, drop_d;
    logic [63:0]      min_q, min_d, max_q, max_d, sum_q, sum_d, last_id_q, last_id_d;
    logic             seen_q, seen_d;

    logic [CNT_W-1:0] bins_q [NUM_BINS];
    logic [CNT_W-1:0] hist_rd_data_q;

    logic             snap_valid_q;
    logic [CNT_W-1:0] snap_count_q, snap_gaps_q, snap_neg_q, snap_drop_q;
    logic [63:0]      snap_min_q, snap_max_q, snap_sum_q;

    logic             take, take_pos, drop_ev;
    logic [63:0]      shifted;
    logic [AW-1:0]    bin_idx;
    logic [64:0]      sum_ext;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (bus.clear) begin
            state_d = S_SWEEP;
            ptr_d   = '0;
        end else if (state_q == S_SWEEP) begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(NUM_BINS - 1)) state_d = S_RUN;
        end
    end

    always_comb begin
        busy     = (state_q == S_SWEEP);
        sweep_en = (state_q == S_SWEEP);
    end

    // ---------------- sample datapath ----------------
    always_comb begin
        take     = bus.in_valid & ~bus.clear & ~busy;
        take_pos = take & ~bus.in_latency[63];
        drop_ev  = bus.in_valid & ~bus.clear & busy;
        shifted  = bus.in_latency >> BIN_SHIFT;
        bin_idx  = (shifted > 64'(NUM_BINS - 1)) ? AW'(NUM_BINS - 1) : shifted[AW-1:0];
        sum_ext  = {1'b0, sum_q} + {1'b0, bus.in_latency};
    end

    always_comb begin
        count_d   = count_q;
        gaps_d    = gaps_q;
        neg_d     = neg_q;
        drop_d    = drop_q;
        min_d     = min_q;
        max_d     = max_q;
        sum_d     = sum_q;
        last_id_d = last_id_q;
        seen_d    = seen_q;
        if (bus.clear) begin
            count_d = '0;
            gaps_d  = '0;
            neg_d   = '0;
            drop_d  = '0;
            min_d   = '1;
            max_d   = '0;
            sum_d   = '0;
            seen_d  = 1'b0;
        end else if (drop_ev) begin
            drop_d = sat_inc(drop_q);
        end else if (take) begin
            if (seen_q && (bus.in_update_id != last_id_q + 64'd1)) gaps_d = sat_inc(gaps_q);
            last_id_d = bus.in_update_id;
            seen_d    = 1'b1;
            if (!take_pos) begin
                neg_d = sat_inc(neg_q);
            end else begin
                count_d = sat_inc(count_q);
                if (bus.in_latency < min_q) min_d = bus.in_latency;
                if (bus.in_latency > max_q) max_d = bus.in_latency;
                sum_d = sum_ext[64] ? '1 : sum_ext[63:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            gaps_q    <= '0;
            neg_q     <= '0;
            drop_q    <= '0;
            min_q     <= '1;
            max_q     <= '0;
            sum_q     <= '0;
            last_id_q <= '0;
            seen_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            gaps_q    <= gaps_d;
            neg_q     <= neg_d;
            drop_q    <= drop_d;
            min_q     <= min_d;
            max_q     <= max_d;
            sum_q     <= sum_d;
            last_id_q <= last_id_d;
            seen_q    <= seen_d;
        end
    end

    // Bins carry no reset: the sweep that follows every reset/clear zeroes them.
    always_ff @(posedge clk) begin
        if (sweep_en)      bins_q[ptr_q]   <= '0;
        else if (take_pos) bins_q[bin_idx] <= sat_inc(bins_q[bin_idx]);
    end

    // ---------------- readout ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_rd_data_q <= '0;
            snap_valid_q   <= 1'b0;
            snap_count_q   <= '0;
            snap_gaps_q    <= '0;
            snap_neg_q     <= '0;
            snap_drop_q    <= '0;
            snap_min_q     <= '1;
            snap_max_q     <= '0;
            snap_sum_q     <= '0;
        end else begin
            hist_rd_data_q <= bins_q[bus.hist_rd_addr];
            snap_valid_q   <= bus.snap_req;
            if (bus.snap_req) begin
                snap_count_q <= count_q;
                snap_gaps_q  <= gaps_q;
                snap_neg_q   <= neg_q;
                snap_drop_q  <= drop_q;
                snap_min_q   <= min_q;
                snap_max_q   <= max_q;
                snap_sum_q   <= sum_q;
            end
        end
    end

    assign bus.busy         = busy;
    assign bus.snap_valid   = snap_valid_q;
    assign bus.snap_count   = snap_count_q;
    assign bus.snap_min     = snap_min_q;
    assign bus.snap_max     = snap_max_q;
    assign bus.snap_sum     = snap_sum_q;
    assign bus.snap_gaps    = snap_gaps_q;
    assign bus.snap_neg     = snap_neg_q;
    assign bus.snap_drop    = snap_drop_q;
    assign bus.hist_rd_data = hist_rd_data_q;
endmodule
